// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle control sequencer
package mc_pkg;

    // Controller states; the numeric values are visible on the debug state port.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

    // Opcode field values recognised in DECODE.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // ALU operation select.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select.
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL = 2'b11;

    // Next-PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Trap cause codes.
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Datapath control word produced every cycle.
    typedef struct packed {
        logic       pc_we;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that hold a memory access open and wait on mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_if.sv
// rtl/mc_if.sv - control sequencer to datapath signal bundle
interface mc_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_we;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegDest;
    logic             MemtoReg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic [3:0]       state;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, opcode, zero, mem_ready,
        output pc_we, IorD, MemRead, MemWrite, IRWrite, RegDest, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, trap,
               trap_cause, instr_count
    );

    modport slave (
        output run, opcode, zero, mem_ready,
        input  pc_we, IorD, MemRead, MemWrite, IRWrite, RegDest, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, trap,
               trap_cause, instr_count
    );

endinterface

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - memory wait-cycle counter with timeout compare
module mc_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count;

    // Count unanswered wait cycles; stop at the limit so the counter never wraps.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (count_en && (count != LIMIT)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS control sequencer
module mc_control
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32,
    parameter bit ADDI_EN = 1'b1
) (
    input  logic clk,
    input  logic reset,
    mc_if.master bus
);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       cause_q;
    logic [1:0]       cause_d;
    logic             trap_q;
    logic [CNT_W-1:0] count_q;
    logic             retire;
    logic             expired;
    logic             wait_en;
    logic             wait_clear;
    ctrl_t            ctrl;

    // A memory state only waits while it is actually issuing a request;
    // an idle FETCH (run low) keeps the counter parked at zero.
    assign wait_en    = is_mem_state(state_q) && !bus.mem_ready &&
                        ((state_q != S_FETCH) || bus.run);
    assign wait_clear = (state_d != state_q) || ((state_q == S_FETCH) && !bus.run);

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (wait_clear),
        .count_en (wait_en),
        .expired  (expired)
    );

    // Next-state selection, trap cause capture and retire detection.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.run) begin
                    if (bus.mem_ready) begin
                        state_d = S_DECODE;
                    end else if (expired) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:    state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:      state_d = S_BRANCH;
                    OP_J:        state_d = S_JUMP;
                    OP_ADDI: begin
                        if (ADDI_EN) begin
                            state_d = S_ADDIEX;
                        end else begin
                            state_d = S_TRAP;
                            cause_d = CAUSE_ILLEGAL;
                        end
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Sequencer state, sticky trap flag and cause, retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cause_q <= CAUSE_NONE;
            trap_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_d == S_TRAP) begin
                trap_q <= 1'b1;
            end
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Control word decoded from the registered state; only the FETCH
    // write strobes and the branch PC write look at live inputs.
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                if (bus.run) begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.ir_write  = bus.mem_ready;
                    ctrl.pc_we     = bus.mem_ready;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SL;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dest  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_we     = bus.zero;
            end
            S_JUMP: begin
                ctrl.pc_we     = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
        // Keep the datapath quiet while reset is held.
        if (!reset) begin
            ctrl = '0;
        end
    end

    assign bus.pc_we       = ctrl.pc_we;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.RegDest     = ctrl.reg_dest;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.state       = state_q;
    assign bus.trap        = trap_q;
    assign bus.trap_cause  = cause_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - self-checking bench for the multi-cycle control sequencer
module tb_mc_control;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BAD   = 6'h3F;

    localparam int ST_FETCH  = 0;
    localparam int ST_DECODE = 1;
    localparam int ST_MEMADR = 2;
    localparam int ST_MEMRD  = 3;
    localparam int ST_MEMWB  = 4;
    localparam int ST_MEMWR  = 5;
    localparam int ST_EXEC   = 6;
    localparam int ST_ALUWB  = 7;
    localparam int ST_BRANCH = 8;
    localparam int ST_JUMP   = 9;
    localparam int ST_ADDIEX = 10;
    localparam int ST_ADDIWB = 11;
    localparam int ST_TRAP   = 15;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       run       = 1'b0;
    logic       zero      = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode    = 6'h00;

    int n_checks  = 0;
    int n_fail    = 0;
    int exp_count = 0;

    // Expected control word per state with run = 1, mem_ready = 0, zero = 0.
    // Bit order: pc_we IorD MemRead MemWrite IRWrite RegDest MemtoReg RegWrite ALUSrcA ALUSrcB ALUOp PCSource
    logic [14:0] exp_tab [16];
    logic [5:0]  ops [6];

    typedef struct {
        int   st;
        logic mr;
        logic r;
    } tr_t;
    tr_t tq[$];

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         wf;
        int         wm;
        int         cycles;
    } vec_t;
    vec_t vecs [9];

    mc_if #(.CNT_W(32)) ifa ();
    mc_if #(.CNT_W(4))  ifb ();

    assign ifa.run       = run;
    assign ifa.opcode    = opcode;
    assign ifa.zero      = zero;
    assign ifa.mem_ready = mem_ready;
    assign ifb.run       = run;
    assign ifb.opcode    = opcode;
    assign ifb.zero      = zero;
    assign ifb.mem_ready = mem_ready;

    mc_control #(.TIMEOUT(15), .CNT_W(32), .ADDI_EN(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    mc_control #(.TIMEOUT(15), .CNT_W(4), .ADDI_EN(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [14:0] outs_a();
        return {ifa.pc_we, ifa.IorD, ifa.MemRead, ifa.MemWrite, ifa.IRWrite, ifa.RegDest,
                ifa.MemtoReg, ifa.RegWrite, ifa.ALUSrcA, ifa.ALUSrcB, ifa.ALUOp, ifa.PCSource};
    endfunction

    function automatic logic [14:0] exp_outs(input int st, input logic r, input logic mr, input logic z);
        logic [14:0] v;
        v = exp_tab[st];
        if (st == ST_FETCH) begin
            if (!r) begin
                v = '0;
            end else if (mr) begin
                v[14] = 1'b1;
                v[10] = 1'b1;
            end
        end
        if ((st == ST_BRANCH) && z) v[14] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: compare at the falling edge, then advance past the rising edge.
    task automatic step_check(input int st_exp);
        @(negedge clk);
        check("state", 64'(ifa.state), 64'(st_exp));
        check("ctrl", 64'(outs_a()), 64'(exp_outs(st_exp, run, mem_ready, zero)));
        check("excl", 64'({ifa.MemRead & ifa.MemWrite, ifa.RegWrite & ifa.MemWrite}), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_state_a", 64'(ifa.state), 64'(ST_FETCH));
        check("rst_trap_a", 64'({ifa.trap, ifa.trap_cause}), 64'd0);
        check("rst_count_a", 64'(ifa.instr_count), 64'd0);
        check("rst_state_b", 64'(ifb.state), 64'(ST_FETCH));
        check("rst_trap_b", 64'({ifb.trap, ifb.trap_cause}), 64'd0);
        check("rst_count_b", 64'(ifb.instr_count), 64'd0);
        reset = 1'b1;
        exp_count = 0;
    endtask

    task automatic push(input int st, input logic mr, input logic r);
        tr_t e;
        e.st = st;
        e.mr = mr;
        e.r  = r;
        tq.push_back(e);
    endtask

    task automatic add_wait(input int st, input int w);
        for (int i = 0; i < w; i++) push(st, 1'b0, 1'b1);
        push(st, 1'b1, 1'b1);
    endtask

    task automatic add_plain(input int st);
        push(st, 1'($urandom_range(0, 1)), 1'b1);
    endtask

    // Reference path of one instruction, written from the instruction's
    // documented state walk: idle fetches, waited fetch, decode, then the
    // opcode-specific tail.
    task automatic build(input logic [5:0] op, input int idle, input int wf, input int wm);
        tq.delete();
        for (int i = 0; i < idle; i++) push(ST_FETCH, 1'($urandom_range(0, 1)), 1'b0);
        add_wait(ST_FETCH, wf);
        add_plain(ST_DECODE);
        case (op)
            OP_RTYPE: begin add_plain(ST_EXEC); add_plain(ST_ALUWB); end
            OP_LW:    begin add_plain(ST_MEMADR); add_wait(ST_MEMRD, wm); add_plain(ST_MEMWB); end
            OP_SW:    begin add_plain(ST_MEMADR); add_wait(ST_MEMWR, wm); end
            OP_BEQ:   add_plain(ST_BRANCH);
            OP_J:     add_plain(ST_JUMP);
            default:  begin add_plain(ST_ADDIEX); add_plain(ST_ADDIWB); end
        endcase
    endtask

    task automatic run_trace(input logic [5:0] op, input logic z);
        foreach (tq[i]) begin
            run       = tq[i].r;
            mem_ready = tq[i].mr;
            opcode    = op;
            zero      = z;
            step_check(tq[i].st);
        end
        exp_count++;
        check("instr_count", 64'(ifa.instr_count), 64'(exp_count));
    endtask

    // Memory responder: answers after wf/wm unanswered cycles in each memory state.
    task automatic run_vec(input vec_t v);
        int cyc;
        int w;
        int last;
        int st;
        int need;
        bit left;
        cyc    = 0;
        w      = 0;
        last   = ST_FETCH;
        left   = 1'b0;
        opcode = v.op;
        zero   = v.z;
        run    = 1'b1;
        while (cyc < 64) begin
            st = int'(ifa.state);
            if (st != last) w = 0;
            need = (st == ST_FETCH) ? v.wf : v.wm;
            mem_ready = (w >= need);
            @(posedge clk);
            #1;
            cyc++;
            w++;
            last = st;
            if (int'(ifa.state) == ST_TRAP) break;
            if (int'(ifa.state) != ST_FETCH) left = 1'b1;
            else if (left) break;
        end
        check("vec_cycles", 64'(cyc), 64'(v.cycles));
        exp_count++;
        check("vec_count", 64'(ifa.instr_count), 64'(exp_count));
        check("vec_trap", 64'(ifa.trap), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_tab[i] = '0;
        exp_tab[ST_FETCH]  = 15'b0_0_1_0_0_0_0_0_0_01_00_00;
        exp_tab[ST_DECODE] = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
        exp_tab[ST_MEMADR] = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
        exp_tab[ST_MEMRD]  = 15'b0_1_1_0_0_0_0_0_0_00_00_00;
        exp_tab[ST_MEMWB]  = 15'b0_0_0_0_0_0_1_1_0_00_00_00;
        exp_tab[ST_MEMWR]  = 15'b0_1_0_1_0_0_0_0_0_00_00_00;
        exp_tab[ST_EXEC]   = 15'b0_0_0_0_0_0_0_0_1_00_10_00;
        exp_tab[ST_ALUWB]  = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
        exp_tab[ST_BRANCH] = 15'b0_0_0_0_0_0_0_0_1_00_01_01;
        exp_tab[ST_JUMP]   = 15'b1_0_0_0_0_0_0_0_0_00_00_10;
        exp_tab[ST_ADDIEX] = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
        exp_tab[ST_ADDIWB] = 15'b0_0_0_0_0_0_0_1_0_00_00_00;
        ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW;
        ops[3] = OP_BEQ;   ops[4] = OP_J;  ops[5] = OP_ADDI;

        vecs[0] = '{OP_RTYPE, 1'b0, 0, 0, 4};
        vecs[1] = '{OP_LW,    1'b0, 0, 3, 8};
        vecs[2] = '{OP_SW,    1'b0, 1, 0, 5};
        vecs[3] = '{OP_BEQ,   1'b0, 0, 0, 3};
        vecs[4] = '{OP_BEQ,   1'b1, 0, 0, 3};
        vecs[5] = '{OP_J,     1'b0, 2, 0, 5};
        vecs[6] = '{OP_ADDI,  1'b0, 0, 0, 4};
        vecs[7] = '{OP_LW,    1'b1, 15, 15, 35};
        vecs[8] = '{OP_SW,    1'b0, 0, 2, 6};

        run = 1'b1; mem_ready = 1'b1; opcode = OP_RTYPE; zero = 1'b0;
        do_reset(2);

        // R-type walk, lw with three wait cycles, beq not-taken then taken.
        build(OP_RTYPE, 0, 0, 0); run_trace(OP_RTYPE, 1'b0);
        build(OP_LW, 0, 0, 3);    run_trace(OP_LW, 1'b0);
        check("lw_trap", 64'(ifa.trap), 64'd0);
        build(OP_BEQ, 0, 0, 0);   run_trace(OP_BEQ, 1'b0);
        build(OP_BEQ, 0, 0, 0);   run_trace(OP_BEQ, 1'b1);

        // Vector table with a memory responder.
        foreach (vecs[i]) run_vec(vecs[i]);

        // Randomised instruction stream against the path model.
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            int idle;
            int wf;
            int wm;
            op   = ops[$urandom_range(0, 5)];
            idle = $urandom_range(0, 2);
            wf   = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            wm   = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            build(op, idle, wf, wm);
            run_trace(op, 1'($urandom_range(0, 1)));
        end

        // Idle run = 0 keeps the wait count at zero; ready at count 15 wins.
        do_reset(1);
        run = 1'b0; mem_ready = 1'b0;
        repeat (20) step_check(ST_FETCH);
        run = 1'b1;
        repeat (15) step_check(ST_FETCH);
        mem_ready = 1'b1;
        step_check(ST_FETCH);
        check("boundary_state", 64'(ifa.state), 64'(ST_DECODE));
        check("boundary_trap", 64'(ifa.trap), 64'd0);

        // Fetch timeout: 16 unanswered cycles then TRAP, sticky until reset.
        do_reset(1);
        run = 1'b1; mem_ready = 1'b0;
        repeat (16) step_check(ST_FETCH);
        check("to_state", 64'(ifa.state), 64'(ST_TRAP));
        check("to_trap", 64'({ifa.trap, ifa.trap_cause}), 64'b110);
        check("to_ctrl", 64'(outs_a()), 64'd0);
        mem_ready = 1'b1;
        repeat (4) step_check(ST_TRAP);
        check("to_hold", 64'({ifa.trap, ifa.trap_cause}), 64'b110);
        do_reset(1);

        // Illegal opcode trap, persists until reset.
        run = 1'b1; mem_ready = 1'b1; opcode = OP_BAD;
        step_check(ST_FETCH);
        step_check(ST_DECODE);
        check("ill_state", 64'(ifa.state), 64'(ST_TRAP));
        check("ill_trap", 64'({ifa.trap, ifa.trap_cause}), 64'b101);
        repeat (3) step_check(ST_TRAP);
        check("ill_hold", 64'({ifa.trap, ifa.trap_cause}), 64'b101);
        do_reset(1);

        // addi decodes on the ADDI_EN = 1 instance, traps on the other.
        opcode = OP_ADDI; mem_ready = 1'b1;
        step_check(ST_FETCH);
        step_check(ST_DECODE);
        check("addi_a_state", 64'(ifa.state), 64'(ST_ADDIEX));
        check("addi_b_state", 64'(ifb.state), 64'(ST_TRAP));
        check("addi_b_trap", 64'({ifb.trap, ifb.trap_cause}), 64'b101);
        step_check(ST_ADDIEX);
        step_check(ST_ADDIWB);
        do_reset(1);

        // 17 jumps: 4-bit counter wraps to 1.
        for (int n = 0; n < 17; n++) begin
            build(OP_J, 0, 0, 0);
            run_trace(OP_J, 1'b0);
        end
        check("wrap_b", 64'(ifb.instr_count), 64'd1);

        // Reset in the middle of a store access.
        do_reset(1);
        run = 1'b1; opcode = OP_SW; mem_ready = 1'b1;
        step_check(ST_FETCH);
        mem_ready = 1'b0;
        step_check(ST_DECODE);
        step_check(ST_MEMADR);
        @(negedge clk);
        check("sw_state", 64'(ifa.state), 64'(ST_MEMWR));
        check("sw_write", 64'(ifa.MemWrite), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_count = 0;
        @(negedge clk);
        check("rstwr_state", 64'(ifa.state), 64'(ST_FETCH));
        check("rstwr_write", 64'(ifa.MemWrite), 64'd0);
        check("rstwr_count", 64'(ifa.instr_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle MIPS control sequencer; the parametrised successor to the single-cycle control path.
- Replaces the combinational opcode decode with a Moore FSM that drives a shared-memory, shared-ALU datapath.
- Adds:
  - a memory ready/wait handshake with a bounded timeout;
  - an illegal-opcode trap;
  - a retired-instruction counter.
- Sits between the instruction register opcode field and the multicycle datapath muxes and enables.

Parameters:
- TIMEOUT, 15, max cycles to wait for mem_ready in any memory state before trapping (1..255).
- CNT_W, 32, width of the retired-instruction counter.
- ADDI_EN, 1, 1 = decode addi (opcode 0x08); 0 = treat addi as illegal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- run  in  1  1 = FSM may leave FETCH; 0 = hold in FETCH, no memory request.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_we  out  1  PC write enable.
- IorD  out  1  memory address source: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  load IR.
- RegDest  out  1  write-register select: 1 = rd, 0 = rt.
- MemtoReg  out  1  write-data select: 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A operand: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B operand: 00 = B, 01 = 4, 10 = sign-extend, 11 = sign-extend<<2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct decode.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding, for debug.
- trap  out  1  sticky error flag.
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state = FETCH;
  - all outputs 0, including trap, trap_cause, instr_count and the wait counter.
  - Reset takes priority over every other event, including mid-access and from TRAP.
- States: FETCH(0), DECODE(1), MEMADR(2), MEMRD(3), MEMWB(4), MEMWR(5), EXEC(6), ALUWB(7), BRANCH(8), JUMP(9), ADDIEX(10), ADDIWB(11), TRAP(15). Outputs are a Moore decode of state, except where noted.
- FETCH, when run = 1:
  - asserts MemRead, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - mem_ready = 0: stay in FETCH, wait counter increments.
  - mem_ready = 1: IRWrite = 1 and pc_we = 1 in the same cycle (Mealy on mem_ready); go to DECODE.
- FETCH, when run = 0: MemRead = 0, no transition, wait counter held at 0.
- DECODE: ALUSrcB = 11, ALUOp = 00 (branch target precompute). Next state by opcode:
  - 0x00 -> EXEC;
  - 0x23 or 0x2B -> MEMADR;
  - 0x04 -> BRANCH;
  - 0x02 -> JUMP;
  - 0x08 with ADDI_EN = 1 -> ADDIEX;
  - any other opcode -> TRAP with cause 01.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD:
  - MemRead = 1, IorD = 1.
  - Waits on mem_ready like FETCH; on ready -> MEMWB.
- MEMWR:
  - MemWrite = 1, IorD = 1.
  - Waits on mem_ready; on ready -> FETCH and the instruction retires.
- Memory timeout (FETCH, MEMRD, MEMWR): wait counter counts cycles with mem_ready = 0. If it reaches TIMEOUT and mem_ready is still 0, go to TRAP with cause 10. mem_ready = 1 in the same cycle the count reaches TIMEOUT wins: no trap.
- Wait counter clears on every state change.
- MEMWB: RegWrite = 1, MemtoReg = 1, RegDest = 0; retire; -> FETCH.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10; -> ALUWB.
- ALUWB: RegWrite = 1, RegDest = 1; retire; -> FETCH.
- BRANCH:
  - ALUSrcA = 1, ALUOp = 01, PCSource = 01.
  - pc_we = zero (Mealy).
  - Retire; -> FETCH.
- JUMP: pc_we = 1, PCSource = 10; retire; -> FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00; -> ADDIWB.
- ADDIWB: RegWrite = 1, RegDest = 0; retire; -> FETCH.
- TRAP:
  - all enables 0;
  - trap = 1, trap_cause held;
  - exits only through reset.
- Retire: instr_count += 1 on the final cycle of each instruction. Wraps modulo 2^CNT_W, with no saturation.
- No state ever asserts MemRead and MemWrite together. No state ever asserts RegWrite and MemWrite together.

Decomposition:
- Shared package mc_pkg holds:
  - state encoding constants;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - ALUOp, ALUSrcB and PCSource encodings;
  - trap cause codes.
- One natural sub-module: mc_wait_timer. It holds the wait counter and timeout compare: inputs clk, reset, clear, count_en; output expired.

Test Plan:
- reset low for 2 cycles, run = 1, mem_ready = 1, opcode = 0x00 -> states FETCH, DECODE, EXEC, ALUWB, FETCH; RegWrite = 1 and RegDest = 1 in ALUWB; instr_count = 1.
- lw (0x23) with mem_ready low 3 cycles in MEMRD -> MEMRD held for 4 cycles, then MEMWB with MemtoReg = 1; total 8 cycles; trap = 0.
- beq (0x04), zero = 0 then zero = 1 on a second beq -> pc_we = 0 in the first BRANCH cycle, pc_we = 1 in the second; instr_count increments both times.
- TIMEOUT = 15, mem_ready stuck 0 in FETCH -> TRAP on the 16th cycle, trap_cause = 10, all enables 0; mem_ready = 1 exactly at count 15 -> no trap.
- opcode = 0x3F, and separately opcode = 0x08 with ADDI_EN = 0 -> TRAP, trap_cause = 01; TRAP persists until reset low, then FETCH with outputs cleared.
- CNT_W = 4 bench: 17 j (0x02) instructions -> instr_count = 1 (wrap). Reset asserted during MEMWR -> MemWrite = 0 on the next cycle, state = FETCH.
